// File: rtl/l2_pmem_burst_responder.sv
// Memory-side responder for the L2 pmem interface: turns one full-line read or write
// into a BEATS-long burst on the DRAM port and pulses resp_o when the line has moved.
module l2_pmem_burst_responder #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic               read_o,
  output logic               write_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int OFF   = $clog2(LINE_W / 8);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [LINE_W-1:0]   buf_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                read_q;
  logic                write_q;
  logic                resp_q;
  logic [ADDR_W-1:0]   addr_d;
  logic                unused_addr_bits;

  // Bursts always start at the line boundary; the beat index is implied by cnt_q.
  assign addr_d           = {address_i[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign unused_addr_bits = ^address_i[OFF-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_q <= 1'b0;
          // Write-back wins over fill when both are requested together.
          if (write_i) begin
            buf_q   <= line_i;
            addr_q  <= addr_d;
            cnt_q   <= '0;
            write_q <= 1'b1;
            state_q <= WR_BURST;
          end else if (read_i) begin
            addr_q  <= addr_d;
            cnt_q   <= '0;
            read_q  <= 1'b1;
            state_q <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            buf_q[cnt_q*BURST_W +: BURST_W] <= burst_i;
            if (cnt_q == LAST_BEAT) begin
              cnt_q   <= '0;
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        WR_BURST: begin
          if (resp_i) begin
            if (cnt_q == LAST_BEAT) begin
              cnt_q   <= '0;
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          // Requests are not sampled here, giving L2 this edge to drop them.
          resp_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          read_q  <= 1'b0;
          write_q <= 1'b0;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

  assign resp_o    = resp_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign address_o = addr_q;
  assign line_o    = buf_q;
  assign burst_o   = write_q ? buf_q[cnt_q*BURST_W +: BURST_W] : '0;

endmodule
